pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard and interlock controller for the in-order MIPS pipeline, generalising the fixed 5-stage hazard unit to DEPTH post-decode stages with per-instruction result latency. It keeps a registered scoreboard of in-flight destination registers, one entry per stage from E to W. From the scoreboard it generates stall and flush controls for the F, D, E and M stage registers, decode-stage forwarding selects for branch compares, and execute-stage forwarding selects. It also freezes the front of the pipe while a multi-cycle execute unit is busy.

## Interface
- DEPTH, 3: post-decode stages E..W, indexed 1..DEPTH (1=E, DEPTH=W); minimum 3
- AW, 5: register address width
- SW, $clog2(DEPTH+1): width of stage-index and latency fields
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  D stage holds a real instruction
- id_rs, id_rt  in  AW  source registers of D instruction
- id_use_rs, id_use_rt  in  1  operand actually read
- id_branch  in  1  D instruction compares operands in D
- id_wr_en  in  1  D instruction writes id_dst
- id_dst  in  AW  destination register
- id_lat  in  SW  stage whose end produces the result (1=ALU, 2=load)
- id_redirect  in  1  branch/jump taken in D
- ex_busy  in  1  multi-cycle unit in E not finished
- stall_f, stall_d  out  1  hold PC / D register
- flush_d  out  1  clear D register
- stall_e  out  1  hold E register
- flush_e, flush_m  out  1  insert bubble into E / M register
- fwd_a_d, fwd_b_d  out  SW  D-operand source stage; 0 = register file
- fwd_a_e, fwd_b_e  out  SW  E-operand source stage; 0 = register file

## Operation
- Scoreboard entry per stage k: {valid, wr_en, dst, lat}. Stage 1 also holds rs_e and rt_e.
- A match on operand r exists when r!=0, the operand is used, and some entry has valid & wr_en & dst==r. The youngest match (smallest k) wins.
- id_lat is normalised before use: 0 is treated as 1; values >= DEPTH are clamped to DEPTH-1.
- Load-use / latency stall (non-branch): stall when the youngest match has k < lat.
- Branch stall: stall when the youngest match has k <= lat.
- Branch forwarding: fwd_x_d = k when 2 <= k <= DEPTH-1 and k > lat. A match at DEPTH gives 0, because the register file writes before it reads.
- hz = id_valid & (rs or rt stall condition).
- fwd_x_e = youngest k in 2..DEPTH matching rs_e/rt_e with k > lat; otherwise 0.
- ex_busy=1 takes priority over hz:
  - stall_f, stall_d, stall_e and flush_m are 1; flush_e is 0.
  - Stall/forward conditions are still computed against the held state.
- Otherwise, when hz=1: stall_f, stall_d and flush_e are 1.
- flush_d = id_redirect & ~stall_d. A redirect during any stall is ignored; decode re-asserts it once the branch resolves.
- Writes to $0 never match.

## Timing
- All outputs are combinational from scoreboard state plus inputs. Zero cycles from input to output.
- Scoreboard update at posedge:
  - rst: all entries invalid, rs_e and rt_e cleared.
  - ex_busy: stage 1 holds; stage 2 gets a bubble; stages 3..DEPTH shift from k-1.
  - Otherwise: stages shift k <- k-1. Stage 1 <- D entry if id_valid & ~hz, else a bubble.
- While rst=1 all outputs are forced to 0. After rst falls, the first cycle shows all outputs 0 and all fwd selects 0.
- Reset mid-operation discards every in-flight entry; no stall carries over.
- Minimum stall cycles for a dependent non-branch op directly behind its producer: lat-1. For a branch: lat.

## Structure
- pipe_pkg holds:
  - STAGE_E=1, STAGE_M=2 and LAT_ALU=1, LAT_LOAD=2 constants.
  - A packed struct sb_entry_t {valid, wr_en, dst, lat}.
  - FWD_RF=0 constant.
- One sub-module, hazard_match: a priority finder that takes the scoreboard plus one register address and returns found, stage k and lat. It is instantiated four times (rs/rt for D and for E).

## Test plan
- Reset: rst high 2 cycles with id_valid=1 → all outputs 0; afterwards fwd_*_e=0 with an empty scoreboard.
- ALU add $8 (lat 1), then sub $9,$8,$3 → no stall; fwd_a_e=2 when sub is in E.
- lw $9 (lat 2), then add using $9 as rt → exactly one cycle of stall_f=stall_d=flush_e=1, then fwd_b_e=3 (DEPTH=3).
- add $10, then beq $10,$0 → one stall cycle, then fwd_a_d=2 with no stall. With id_redirect=1 in that cycle → flush_d=1; in the stall cycle, flush_d=0.
- ex_busy held 3 cycles with a load in M → stall_f=stall_d=stall_e=flush_m=1 and flush_e=0 for 3 cycles; the load retires; the E instruction then advances with correct fwd.
- DEPTH=5 with a lat-4 producer of $12 followed by a consumer → 3 stall cycles, then fwd_a_e=5. A producer writing $0 followed by a $0 consumer → no stall, fwd 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and scoreboard entry type for the pipeline hazard controller.
package pipe_pkg;

  localparam int SB_AW = 8;
  localparam int SB_SW = 4;

  localparam int STAGE_E  = 1;
  localparam int STAGE_M  = 2;
  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;
  localparam int FWD_RF   = 0;

  typedef struct packed {
    logic             valid;
    logic             wr_en;
    logic [SB_AW-1:0] dst;
    logic [SB_SW-1:0] lat;
  } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_match.sv
// Priority finder: youngest scoreboard stage writing a given register.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  sb_entry_t [DEPTH:1] sb,
  input  logic [SB_AW-1:0]    addr,
  output logic                found,
  output logic [SB_SW-1:0]    stage,
  output logic [SB_SW-1:0]    lat
);

  // Scan oldest to youngest so the youngest hit is the one that sticks.
  always_comb begin
    found = 1'b0;
    stage = '0;
    lat   = '0;
    if (addr != '0) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (sb[k].valid && sb[k].wr_en && sb[k].dst == addr) begin
          found = 1'b1;
          stage = SB_SW'(k);
          lat   = sb[k].lat;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/interlock controller: scoreboard of in-flight writers, stall/flush
// generation and forwarding selects for D-stage branches and E-stage operands.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int AW    = 5,
  parameter int SW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_branch,
  input  logic          id_wr_en,
  input  logic [AW-1:0] id_dst,
  input  logic [SW-1:0] id_lat,
  input  logic          id_redirect,
  input  logic          ex_busy,
  output logic          stall_f,
  output logic          stall_d,
  output logic          flush_d,
  output logic          stall_e,
  output logic          flush_e,
  output logic          flush_m,
  output logic [SW-1:0] fwd_a_d,
  output logic [SW-1:0] fwd_b_d,
  output logic [SW-1:0] fwd_a_e,
  output logic [SW-1:0] fwd_b_e
);

  sb_entry_t [DEPTH:1] sb_q;
  sb_entry_t [DEPTH:1] sb_e;
  logic [SB_AW-1:0]    rs_e_q, rt_e_q;
  logic [SB_AW-1:0]    rs_d, rt_d;
  logic [SB_SW-1:0]    lat_raw, lat_n;
  sb_entry_t           d_entry;

  logic                a_d_found, b_d_found, a_e_found, b_e_found;
  logic [SB_SW-1:0]    a_d_k, b_d_k, a_e_k, b_e_k;
  logic [SB_SW-1:0]    a_d_lat, b_d_lat, a_e_lat, b_e_lat;
  logic                stall_a, stall_b, hz;

  assign rs_d    = id_use_rs ? SB_AW'(id_rs) : '0;
  assign rt_d    = id_use_rt ? SB_AW'(id_rt) : '0;
  assign lat_raw = SB_SW'(id_lat);

  always_comb begin
    lat_n = lat_raw;
    if (lat_raw == '0)
      lat_n = SB_SW'(LAT_ALU);
    else if (lat_raw >= SB_SW'(DEPTH))
      lat_n = SB_SW'(DEPTH - 1);
  end

  assign d_entry = '{valid: 1'b1, wr_en: id_wr_en, dst: SB_AW'(id_dst), lat: lat_n};

  // The E instruction must not match against itself.
  always_comb begin
    sb_e          = sb_q;
    sb_e[STAGE_E] = '0;
  end

  hazard_match #(.DEPTH(DEPTH)) u_match_a_d (
    .sb(sb_q), .addr(rs_d), .found(a_d_found), .stage(a_d_k), .lat(a_d_lat));
  hazard_match #(.DEPTH(DEPTH)) u_match_b_d (
    .sb(sb_q), .addr(rt_d), .found(b_d_found), .stage(b_d_k), .lat(b_d_lat));
  hazard_match #(.DEPTH(DEPTH)) u_match_a_e (
    .sb(sb_e), .addr(rs_e_q), .found(a_e_found), .stage(a_e_k), .lat(a_e_lat));
  hazard_match #(.DEPTH(DEPTH)) u_match_b_e (
    .sb(sb_e), .addr(rt_e_q), .found(b_e_found), .stage(b_e_k), .lat(b_e_lat));

  function automatic logic op_stall(input logic f, input logic [SB_SW-1:0] k,
                                    input logic [SB_SW-1:0] lat, input logic br);
    return f && (br ? (k <= lat) : (k < lat));
  endfunction

  // Branch compares can't take the W value: the register file already has it.
  function automatic logic [SB_SW-1:0] fwd_d_sel(input logic f, input logic [SB_SW-1:0] k,
                                                 input logic [SB_SW-1:0] lat);
    return (f && k >= SB_SW'(STAGE_M) && k <= SB_SW'(DEPTH - 1) && k > lat) ? k
                                                                            : SB_SW'(FWD_RF);
  endfunction

  function automatic logic [SB_SW-1:0] fwd_e_sel(input logic f, input logic [SB_SW-1:0] k,
                                                 input logic [SB_SW-1:0] lat);
    return (f && k > lat) ? k : SB_SW'(FWD_RF);
  endfunction

  assign stall_a = op_stall(a_d_found, a_d_k, a_d_lat, id_branch);
  assign stall_b = op_stall(b_d_found, b_d_k, b_d_lat, id_branch);
  assign hz      = id_valid & (stall_a | stall_b);

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    stall_e = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    fwd_a_d = '0;
    fwd_b_d = '0;
    fwd_a_e = '0;
    fwd_b_e = '0;
    if (!rst) begin
      fwd_a_d = SW'(fwd_d_sel(a_d_found, a_d_k, a_d_lat));
      fwd_b_d = SW'(fwd_d_sel(b_d_found, b_d_k, b_d_lat));
      fwd_a_e = SW'(fwd_e_sel(a_e_found, a_e_k, a_e_lat));
      fwd_b_e = SW'(fwd_e_sel(b_e_found, b_e_k, b_e_lat));
      if (ex_busy) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else if (hz) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
      flush_d = id_redirect & ~stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q   <= '0;
      rs_e_q <= '0;
      rt_e_q <= '0;
    end else if (ex_busy) begin
      sb_q[STAGE_M] <= '0;
      for (int k = 3; k <= DEPTH; k++)
        sb_q[k] <= sb_q[k-1];
    end else begin
      for (int k = 2; k <= DEPTH; k++)
        sb_q[k] <= sb_q[k-1];
      if (id_valid && !hz) begin
        sb_q[STAGE_E] <= d_entry;
        rs_e_q        <= rs_d;
        rt_e_q        <= rt_d;
      end else begin
        sb_q[STAGE_E] <= '0;
        rs_e_q        <= '0;
        rt_e_q        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl at DEPTH=3 and DEPTH=5 against a queue-based pipeline model.
module tb_pipe_hazard_ctrl;

  typedef struct {int v; int wr; int dst; int lat; int rs; int rt;} ent_t;
  typedef ent_t ent_q_t[$];
  typedef struct {int sf; int sd; int fd; int se; int fe; int fm;
                  int fad; int fbd; int fae; int fbe; int hz;} exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0, id_branch = 1'b0;
  logic       id_wr_en = 1'b0, id_redirect = 1'b0, ex_busy = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;
  logic [1:0] lat3 = '0;
  logic [2:0] lat5 = '0;

  logic       sf3, sd3, fd3, se3, fe3, fm3;
  logic [1:0] fad3, fbd3, fae3, fbe3;
  logic       sf5, sd5, fd5, se5, fe5, fm5;
  logic [2:0] fad5, fbd5, fae5, fbe5;

  int total = 0;
  int bad   = 0;
  ent_q_t q3, q5;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DEPTH(3), .AW(5)) u3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
    .id_wr_en(id_wr_en), .id_dst(id_dst), .id_lat(lat3), .id_redirect(id_redirect),
    .ex_busy(ex_busy), .stall_f(sf3), .stall_d(sd3), .flush_d(fd3), .stall_e(se3),
    .flush_e(fe3), .flush_m(fm3), .fwd_a_d(fad3), .fwd_b_d(fbd3),
    .fwd_a_e(fae3), .fwd_b_e(fbe3));

  pipe_hazard_ctrl #(.DEPTH(5), .AW(5)) u5 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
    .id_wr_en(id_wr_en), .id_dst(id_dst), .id_lat(lat5), .id_redirect(id_redirect),
    .ex_busy(ex_busy), .stall_f(sf5), .stall_d(sd5), .flush_d(fd5), .stall_e(se5),
    .flush_e(fe5), .flush_m(fm5), .fwd_a_d(fad5), .fwd_b_d(fbd5),
    .fwd_a_e(fae5), .fwd_b_e(fbe5));

  task automatic cmp(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Position in queue = pipeline stage - 1; returns youngest writer stage or 0.
  function automatic int youngest(ent_q_t q, int d, int lo, int r, output int lt);
    lt = 0;
    if (r == 0) return 0;
    for (int k = lo; k <= d; k++)
      if (q[k-1].v != 0 && q[k-1].wr != 0 && q[k-1].dst == r) begin
        lt = q[k-1].lat;
        return k;
      end
    return 0;
  endfunction

  function automatic exp_t eval(ent_q_t q, int d);
    exp_t e;
    int ra, rb, ka, kb, la, lb, ke, le;
    bit sa, sb;
    e = '{default: 0};
    if (rst) return e;
    ra = id_use_rs ? int'(id_rs) : 0;
    rb = id_use_rt ? int'(id_rt) : 0;
    ka = youngest(q, d, 1, ra, la);
    kb = youngest(q, d, 1, rb, lb);
    sa = (ka != 0) && (id_branch ? (ka <= la) : (ka < la));
    sb = (kb != 0) && (id_branch ? (kb <= lb) : (kb < lb));
    e.hz  = (id_valid && (sa || sb)) ? 1 : 0;
    e.fad = (ka >= 2 && ka <= d - 1 && ka > la) ? ka : 0;
    e.fbd = (kb >= 2 && kb <= d - 1 && kb > lb) ? kb : 0;
    ke = youngest(q, d, 2, q[0].rs, le);
    e.fae = (ke != 0 && ke > le) ? ke : 0;
    ke = youngest(q, d, 2, q[0].rt, le);
    e.fbe = (ke != 0 && ke > le) ? ke : 0;
    if (ex_busy) begin
      e.sf = 1; e.sd = 1; e.se = 1; e.fm = 1;
    end else if (e.hz != 0) begin
      e.sf = 1; e.sd = 1; e.fe = 1;
    end
    e.fd = (id_redirect && e.sd == 0) ? 1 : 0;
    return e;
  endfunction

  function automatic ent_q_t next_q(ent_q_t q, int d, int hz, int lraw);
    ent_t b, n;
    b = '{default: 0};
    n = '{default: 0};
    if (rst) begin
      q.delete();
      for (int k = 0; k < d; k++) q.push_back(b);
      return q;
    end
    if (ex_busy) q.insert(1, b);
    else begin
      if (id_valid && hz == 0) begin
        n.v   = 1;
        n.wr  = id_wr_en ? 1 : 0;
        n.dst = int'(id_dst);
        n.lat = (lraw == 0) ? 1 : ((lraw >= d) ? d - 1 : lraw);
        n.rs  = id_use_rs ? int'(id_rs) : 0;
        n.rt  = id_use_rt ? int'(id_rt) : 0;
      end
      q.push_front(n);
    end
    void'(q.pop_back());
    return q;
  endfunction

  task automatic chk_set(input string tag, input exp_t e, input int sf, input int sd,
                         input int fd, input int se, input int fe, input int fm,
                         input int fad, input int fbd, input int fae, input int fbe);
    cmp({tag, "_stall_f"}, sf, e.sf);
    cmp({tag, "_stall_d"}, sd, e.sd);
    cmp({tag, "_flush_d"}, fd, e.fd);
    cmp({tag, "_stall_e"}, se, e.se);
    cmp({tag, "_flush_e"}, fe, e.fe);
    cmp({tag, "_flush_m"}, fm, e.fm);
    cmp({tag, "_fwd_a_d"}, fad, e.fad);
    cmp({tag, "_fwd_b_d"}, fbd, e.fbd);
    cmp({tag, "_fwd_a_e"}, fae, e.fae);
    cmp({tag, "_fwd_b_e"}, fbe, e.fbe);
  endtask

  always @(negedge clk) begin
    exp_t e3, e5;
    e3 = eval(q3, 3);
    e5 = eval(q5, 5);
    chk_set("d3", e3, sf3, sd3, fd3, se3, fe3, fm3, fad3, fbd3, fae3, fbe3);
    chk_set("d5", e5, sf5, sd5, fd5, se5, fe5, fm5, fad5, fbd5, fae5, fbe5);
    q3 = next_q(q3, 3, e3.hz, int'(lat3));
    q5 = next_q(q5, 5, e5.hz, int'(lat5));
  end

  task automatic drive(input bit r, input bit v, input int rs, input int rt,
                       input bit urs, input bit urt, input bit br, input bit wr,
                       input int dst, input int lat, input bit redir, input bit busy);
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_rs = rs[4:0]; id_rt = rt[4:0];
    id_use_rs = urs; id_use_rt = urt; id_branch = br; id_wr_en = wr;
    id_dst = dst[4:0]; lat3 = lat[1:0]; lat5 = lat[2:0];
    id_redirect = redir; ex_busy = busy;
    #1;
  endtask

  initial begin
    // reset with live inputs
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 8, 9, 1, 1, 0, 1, 10, 1, 1, 1);
      cmp("rst_stall_f", sf3, 0);
      cmp("rst_flush_d", fd3, 0);
      cmp("rst_flush_m", fm3, 0);
      cmp("rst_stall_e5", se5, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp("post_rst_fwd_a_e", fae3, 0);
    cmp("post_rst_fwd_b_e", fbe3, 0);
    cmp("post_rst_stall_f", sf3, 0);
    // ALU producer then ALU consumer
    drive(0, 1, 1, 2, 1, 1, 0, 1, 8, 1, 0, 0);
    drive(0, 1, 8, 3, 1, 1, 0, 1, 9, 1, 0, 0);
    cmp("alu_alu_no_stall", sf3, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp("alu_alu_fwd_a_e", fae3, 2);
    cmp("alu_alu_fwd_b_e", fbe3, 0);
    // load-use
    drive(0, 1, 29, 0, 1, 0, 0, 1, 9, 2, 0, 0);
    drive(0, 1, 4, 9, 1, 1, 0, 1, 10, 1, 0, 0);
    cmp("ld_use_stall_f", sf3, 1);
    cmp("ld_use_stall_d", sd3, 1);
    cmp("ld_use_flush_e", fe3, 1);
    drive(0, 1, 4, 9, 1, 1, 0, 1, 10, 1, 0, 0);
    cmp("ld_use_released", sf3, 0);
    cmp("ld_use_flush_e_off", fe3, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp("ld_use_fwd_b_e", fbe3, 3);
    // ALU producer then branch with redirect
    drive(0, 1, 5, 6, 1, 1, 0, 1, 10, 1, 0, 0);
    drive(0, 1, 10, 0, 1, 1, 1, 0, 0, 0, 1, 0);
    cmp("br_stall_d", sd3, 1);
    cmp("br_flush_d_in_stall", fd3, 0);
    drive(0, 1, 10, 0, 1, 1, 1, 0, 0, 0, 1, 0);
    cmp("br_released", sd3, 0);
    cmp("br_fwd_a_d", fad3, 2);
    cmp("br_flush_d", fd3, 1);
    // busy multi-cycle unit with a load ahead in M
    drive(0, 1, 29, 0, 1, 0, 0, 1, 11, 2, 0, 0);
    drive(0, 1, 7, 6, 1, 1, 0, 1, 13, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 13, 11, 1, 1, 0, 1, 14, 1, 0, 1);
      cmp("busy_stall_f", sf3, 1);
      cmp("busy_stall_e", se3, 1);
      cmp("busy_flush_m", fm3, 1);
      cmp("busy_flush_e", fe3, 0);
    end
    drive(0, 1, 13, 11, 1, 1, 0, 1, 14, 1, 0, 0);
    cmp("busy_done_stall_f", sf3, 0);
    cmp("busy_done_stall_e", se3, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp("busy_after_fwd_a_e", fae3, 2);
    cmp("busy_after_fwd_b_e", fbe3, 0);
    // DEPTH=5 long-latency producer
    drive(0, 1, 1, 2, 1, 1, 0, 1, 12, 4, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 12, 3, 1, 1, 0, 1, 15, 1, 0, 0);
      cmp("lat4_stall_f5", sf5, 1);
    end
    drive(0, 1, 12, 3, 1, 1, 0, 1, 15, 1, 0, 0);
    cmp("lat4_released5", sf5, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp("lat4_fwd_a_e5", fae5, 5);
    // writes to $0 never match
    drive(0, 1, 1, 2, 1, 1, 0, 1, 0, 2, 0, 0);
    drive(0, 1, 0, 0, 1, 1, 0, 1, 16, 1, 0, 0);
    cmp("r0_no_stall3", sf3, 0);
    cmp("r0_no_stall5", sf5, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp("r0_fwd_a_e", fae3, 0);
    cmp("r0_fwd_b_e", fbe3, 0);
    // random traffic over a small register set
    for (int n = 0; n < 4000; n++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
